sync_fifo_ext: RTL and testbench

Parametrised single-clock FIFO that generalises the team's basic synchronous FIFO. It supports any depth (including non-power-of-two), programmable almost-full and almost-empty thresholds, an occupancy count, sticky overflow and underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It is the standard on-chip buffer between single-clock producer and consumer blocks.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 33 +++
 rtl/sync_fifo_ext.sv | 163 ++++++++++++++++
 tb/tb_sync_fifo_ext.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_ext family.
//   - default geometry and threshold constants
//   - read-mode encodings for the FWFT parameter
//   - count-width helper (enough bits to hold 0..depth)
package fifo_pkg;

   localparam int unsigned FIFO_DEF_DATA_WIDTH    = 32;
   localparam int unsigned FIFO_DEF_DEPTH         = 10;
   localparam int unsigned FIFO_DEF_AFULL_THRESH  = FIFO_DEF_DEPTH - 2;
   localparam int unsigned FIFO_DEF_AEMPTY_THRESH = 2;

   localparam bit FIFO_MODE_STD  = 1'b0;
   localparam bit FIFO_MODE_FWFT = 1'b1;

   // Width needed to represent an occupancy of 0..depth inclusive.
   function automatic int unsigned fifo_cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Kept separate so it can be replaced by an SRAM macro.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
module fifo_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 10,
   parameter int unsigned ADDR_W     = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Parametrised single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, occupancy count, sticky
// overflow/underflow flags, synchronous flush and optional FWFT read.
//   clk, rst_n        : clock, async active-low reset
//   w_en, data_in     : write request and data
//   r_en              : read/pop request
//   flush             : synchronous clear of contents (highest priority)
//   clr_err           : synchronous clear of sticky error flags
//   data_out          : read data (registered, or fall-through when FWFT)
//   full, empty       : occupancy flags
//   almost_full/empty : threshold flags
//   count             : occupancy 0..DEPTH
//   overflow/underflow: sticky error flags
module sync_fifo_ext
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = FIFO_DEF_DATA_WIDTH,
   parameter int unsigned DEPTH         = FIFO_DEF_DEPTH,
   parameter int unsigned AFULL_THRESH  = DEPTH - 2,
   parameter int unsigned AEMPTY_THRESH = FIFO_DEF_AEMPTY_THRESH,
   parameter bit          FWFT          = FIFO_MODE_STD,
   parameter int unsigned CNT_W         = fifo_cnt_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  r_en,
   input  logic                  flush,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_accept_c;
   logic                  rd_accept_c;
   logic [DATA_WIDTH-1:0] rd_data_c;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_accept_c),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (rd_data_c)
   );

   // Acceptance; a read frees a slot so a write into a full FIFO is allowed.
   always_comb begin
      rd_accept_c = r_en && !empty_q && !flush;
      wr_accept_c = w_en && (!full_q || rd_accept_c) && !flush;
   end

   // Next-state: pointers, count, flags (from next count) and errors.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q && !clr_err;
      udf_d    = udf_q && !clr_err;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_accept_c) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (rd_accept_c) rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({wr_accept_c, rd_accept_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         // A new error wins over a same-cycle clear.
         if (w_en && full_q && !rd_accept_c) ovf_d = 1'b1;
         if (r_en && empty_q)                udf_d = 1'b1;
      end

      full_d   = (count_d == CNT_W'(DEPTH));
      empty_d  = (count_d == '0);
      afull_d  = (32'(count_d) >= AFULL_THRESH);
      aempty_d = (32'(count_d) <= AEMPTY_THRESH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= (AFULL_THRESH == 0);
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Read data path: registered pop, or fall-through of the head word.
   if (FWFT == FIFO_MODE_STD) begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
         dout_d = dout_q;
         if (rd_accept_c) dout_d = rd_data_c;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) dout_q <= '0;
         else        dout_q <= dout_d;
      end

      assign data_out = dout_q;
   end else begin : g_fwft
      // Forced to zero while empty so the reset value is deterministic.
      assign data_out = empty_q ? '0 : rd_data_c;
   end

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
module tb_sync_fifo_ext;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        w_en, r_en, flush, clr_err;
   logic [31:0] din, dout;
   logic        full, empty, afull, aempty, ovf, udf;
   logic [3:0]  cnt;

   logic        f_w_en, f_r_en, f_flush, f_clr_err;
   logic [31:0] f_din, f_dout;
   logic        f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
   logic [3:0]  f_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sync_fifo_ext #(.DATA_WIDTH(32), .DEPTH(10), .FWFT(1'b0)) u_std (
      .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(din), .r_en(r_en),
      .flush(flush), .clr_err(clr_err), .data_out(dout), .full(full),
      .empty(empty), .almost_full(afull), .almost_empty(aempty),
      .count(cnt), .overflow(ovf), .underflow(udf)
   );

   sync_fifo_ext #(.DATA_WIDTH(32), .DEPTH(10), .FWFT(1'b1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .w_en(f_w_en), .data_in(f_din), .r_en(f_r_en),
      .flush(f_flush), .clr_err(f_clr_err), .data_out(f_dout), .full(f_full),
      .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
      .count(f_cnt), .overflow(f_ovf), .underflow(f_udf)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One clock, then settle past the edge before sampling/driving.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " count"},  32'(cnt),    32'd0);
      chk({tag, " empty"},  32'(empty),  32'd1);
      chk({tag, " full"},   32'(full),   32'd0);
      chk({tag, " aempty"}, 32'(aempty), 32'd1);
      chk({tag, " afull"},  32'(afull),  32'd0);
      chk({tag, " ovf"},    32'(ovf),    32'd0);
      chk({tag, " udf"},    32'(udf),    32'd0);
      chk({tag, " dout"},   dout,        32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      w_en = 0; r_en = 0; flush = 0; clr_err = 0; din = '0;
      f_w_en = 0; f_r_en = 0; f_flush = 0; f_clr_err = 0; f_din = '0;
      #12;
      chk_reset_vals("rst");
      chk("rst f_empty", 32'(f_empty), 32'd1);
      rst_n = 1'b1;
      cyc();

      // FWFT: first word falls through without r_en.
      f_w_en = 1; f_din = 32'd555;
      cyc();
      f_w_en = 0;
      chk("fwft dout", f_dout, 32'd555);
      chk("fwft empty", 32'(f_empty), 32'd0);
      cyc();
      chk("fwft hold", f_dout, 32'd555);
      f_w_en = 1; f_din = 32'd777;
      cyc();
      f_w_en = 0;
      chk("fwft head", f_dout, 32'd555);
      f_r_en = 1;
      cyc();
      chk("fwft next", f_dout, 32'd777);
      cyc();
      f_r_en = 0;
      chk("fwft empty2", 32'(f_empty), 32'd1);
      chk("fwft cnt", 32'(f_cnt), 32'd0);

      // Fill 100..109.
      for (int i = 0; i < 10; i++) begin
         w_en = 1; din = 32'(100 + i);
         cyc();
         chk("fill cnt",   32'(cnt),   32'(i + 1));
         chk("fill afull", 32'(afull), 32'((i + 1) >= 8));
         chk("fill full",  32'(full),  32'((i + 1) == 10));
         chk("fill aempty", 32'(aempty), 32'((i + 1) <= 2));
      end
      din = 32'd200;
      cyc();
      w_en = 0;
      chk("ovf set", 32'(ovf), 32'd1);
      chk("ovf cnt", 32'(cnt), 32'd10);

      // Drain in order.
      for (int i = 0; i < 10; i++) begin
         r_en = 1;
         cyc();
         chk("drain dout",  dout,        32'(100 + i));
         chk("drain empty", 32'(empty), 32'(i == 9));
      end
      cyc();
      r_en = 0;
      chk("udf set",   32'(udf), 32'd1);
      chk("udf hold",  dout,     32'd109);
      chk("udf cnt",   32'(cnt), 32'd0);

      clr_err = 1;
      cyc();
      clr_err = 0;
      chk("clr ovf", 32'(ovf), 32'd0);
      chk("clr udf", 32'(udf), 32'd0);

      // Move pointers to 7, then fill across the wrap.
      for (int i = 0; i < 7; i++) begin
         w_en = 1; din = 32'(i);
         cyc();
      end
      w_en = 0;
      r_en = 1;
      for (int i = 0; i < 7; i++) cyc();
      r_en = 0;
      chk("wrap pre empty", 32'(empty), 32'd1);
      for (int i = 0; i < 10; i++) begin
         w_en = 1; din = 32'(300 + i);
         cyc();
      end
      chk("wrap full", 32'(full), 32'd1);
      r_en = 1; w_en = 1; din = 32'd999;
      cyc();
      w_en = 0;
      chk("rw full dout", dout,      32'd300);
      chk("rw full cnt",  32'(cnt),  32'd10);
      chk("rw full ovf",  32'(ovf),  32'd0);
      for (int i = 1; i <= 10; i++) begin
         cyc();
         chk("wrap rd", dout, (i == 10) ? 32'd999 : 32'(300 + i));
      end
      r_en = 0;
      chk("wrap empty", 32'(empty), 32'd1);

      // Simultaneous read/write on empty.
      r_en = 1; w_en = 1; din = 32'd42;
      cyc();
      w_en = 0;
      chk("erw cnt",  32'(cnt), 32'd1);
      chk("erw udf",  32'(udf), 32'd1);
      chk("erw dout", dout,     32'd999);
      cyc();
      r_en = 0;
      chk("erw rd",    dout,       32'd42);
      chk("erw empty", 32'(empty), 32'd1);

      // Flush with five words stored; requests are ignored that cycle.
      for (int i = 0; i < 5; i++) begin
         w_en = 1; din = 32'(500 + i);
         cyc();
      end
      chk("pre flush cnt", 32'(cnt), 32'd5);
      flush = 1; w_en = 1; r_en = 1; din = 32'd7;
      cyc();
      flush = 0; w_en = 0; r_en = 0;
      chk("flush cnt",   32'(cnt),   32'd0);
      chk("flush empty", 32'(empty), 32'd1);
      chk("flush udf",   32'(udf),   32'd1);
      chk("flush ovf",   32'(ovf),   32'd0);
      chk("flush dout",  dout,       32'd42);

      // New error in the same cycle as clr_err keeps the flag.
      clr_err = 1; r_en = 1;
      cyc();
      r_en = 0;
      chk("clr+err udf", 32'(udf), 32'd1);
      cyc();
      clr_err = 0;
      chk("clr udf2", 32'(udf), 32'd0);

      // Mid-operation reset with count=4.
      for (int i = 0; i < 4; i++) begin
         w_en = 1; din = 32'(600 + i);
         cyc();
      end
      w_en = 0; r_en = 1;
      cyc();
      r_en = 0; w_en = 1; din = 32'd604;
      cyc();
      w_en = 0;
      chk("pre rst dout", dout,     32'd600);
      chk("pre rst cnt",  32'(cnt), 32'd4);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async rst");
      #4;
      rst_n = 1'b1;
      cyc();
      chk("post rst cnt", 32'(cnt), 32'd0);
      r_en = 1;
      cyc();
      r_en = 0;
      chk("post rst udf",  32'(udf), 32'd1);
      chk("post rst dout", dout,     32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
